// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared definitions for the RV32M multiply/divide unit: operation codes
//   (chosen outside the range used by the single-cycle ALU), the control FSM
//   state type and small op-code classification helpers.
//   Optional feature macro used by mul_div_unit: MULDIV_FAST_MUL_EN.
package mul_div_unit_pkg;

  localparam logic [4:0] OPMUL    = 5'd16;
  localparam logic [4:0] OPMULH   = 5'd17;
  localparam logic [4:0] OPMULHSU = 5'd18;
  localparam logic [4:0] OPMULHU  = 5'd19;
  localparam logic [4:0] OPDIV    = 5'd20;
  localparam logic [4:0] OPDIVU   = 5'd21;
  localparam logic [4:0] OPREM    = 5'd22;
  localparam logic [4:0] OPREMU   = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True for the four multiply flavours.
  function automatic logic is_mul_op(input logic [4:0] op);
    logic r;
    case (op)
      OPMUL, OPMULH, OPMULHSU, OPMULHU: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the four divide/remainder flavours.
  function automatic logic is_div_op(input logic [4:0] op);
    logic r;
    case (op)
      OPDIV, OPDIVU, OPREM, OPREMU: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

  // rs1 is interpreted as two's complement.
  function automatic logic is_signed_a(input logic [4:0] op);
    logic r;
    case (op)
      OPMULH, OPMULHSU, OPDIV, OPREM: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // rs2 is interpreted as two's complement (MULHSU keeps rs2 unsigned).
  function automatic logic is_signed_b(input logic [4:0] op);
    logic r;
    case (op)
      OPMULH, OPDIV, OPREM: r = 1'b1;
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_div_unit_iter_core.sv
// muldiv_iter_core
//   Unsigned iterative datapath shared by multiply and divide.
//   acc holds {hi, lo}:
//     multiply: hi = partial product, lo = remaining multiplier bits
//               (shift-add, LSB first); after WIDTH steps acc = a*b.
//     divide:   hi = partial remainder, lo = dividend bits shifting out /
//               quotient bits shifting in (restoring); after WIDTH steps
//               hi = remainder, lo = quotient.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture op_a into lo, op_b as multiplicand/divisor, mode
//   step        perform one iteration in the captured mode
//   mode_div    1 = divide, 0 = multiply (sampled with load)
//   op_a, op_b  unsigned operand magnitudes
//   acc         full 2*WIDTH accumulator
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               mode_div,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               mode_q, mode_d;

  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     diff_s;

  // Next-state for one multiply or divide iteration.
  always_comb begin
    acc_d  = acc_q;
    opb_d  = opb_q;
    mode_d = mode_q;
    add_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    // Remainder shifted left by one with the next dividend bit; WIDTH+1 bits
    // because 2*rem+1 can exceed WIDTH bits when the divisor is large.
    shl_s  = acc_q[2*WIDTH-1:WIDTH-1];
    diff_s = shl_s - {1'b0, opb_q};
    if (load) begin
      acc_d  = {{WIDTH{1'b0}}, op_a};
      opb_d  = op_b;
      mode_d = mode_div;
    end else if (step) begin
      if (mode_q) begin
        // Restore on negative trial; quotient bit is the inverted borrow.
        acc_d = {(diff_s[WIDTH] ? shl_s[WIDTH-1:0] : diff_s[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~diff_s[WIDTH]};
      end else if (acc_q[0]) begin
        acc_d = {add_s, acc_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= {(2*WIDTH){1'b0}};
      opb_q  <= {WIDTH{1'b0}};
      mode_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      mode_q <= mode_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Multi-cycle RV32M multiply/divide unit living beside the ALU in EX.
//   One op is accepted with iStart while oBusy=0; the unit iterates WIDTH
//   steps in muldiv_iter_core on operand magnitudes, applies the sign at the
//   end and pulses oDone with oResult valid. Divide-by-zero, signed overflow
//   and unsupported op codes finish without iterating.
//   Optional macro MULDIV_FAST_MUL_EN: multiplies use a combinational
//   2*WIDTH product and finish like the special cases.
// Ports
//   iCLK, iRST_n  clock (rising edge), asynchronous active-low reset
//   iStart        request, sampled only while idle and oBusy=0
//   iControl      op code OPMUL..OPREMU (mul_div_unit_pkg)
//   iA, iB        rs1 / rs2 operands
//   oBusy         high from the cycle after acceptance through the oDone cycle
//   oDone         one-cycle pulse, oResult valid
//   oResult       result, held until the next accepted start
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic [4:0]       iControl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [4:0]        op_q, op_d;
  logic              res_neg_q, res_neg_d;
  logic              special_q, special_d;
  logic [WIDTH-1:0]  spec_res_q, spec_res_d;

  logic              a_neg_s, b_neg_s, res_neg_s;
  logic [WIDTH-1:0]  mag_a_s, mag_b_s;
  logic              special_s;
  logic [WIDTH-1:0]  special_res_s;
  logic              core_load_s, core_step_s;
  logic [2*WIDTH-1:0] core_acc_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]  quo_s, rem_s, fixed_s;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH+1:0] ext_a_s, ext_b_s, fast_prod_s;
`endif

  // Operand decode at issue: magnitudes and final sign of the result.
  always_comb begin
    a_neg_s = is_signed_a(iControl) & iA[WIDTH-1];
    b_neg_s = is_signed_b(iControl) & iB[WIDTH-1];
    mag_a_s = a_neg_s ? (~iA + WIDTH'(1)) : iA;
    mag_b_s = b_neg_s ? (~iB + WIDTH'(1)) : iB;
    case (iControl)
      OPMULH, OPMULHSU, OPDIV: res_neg_s = a_neg_s ^ b_neg_s;
      OPREM:                   res_neg_s = a_neg_s;
      default:                 res_neg_s = 1'b0;
    endcase
  end

  // Results that need no iteration.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = ZERO;
`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending into 2*WIDTH+2 bits makes the unsigned product equal the
    // signed/mixed product modulo 2^(2*WIDTH+2).
    ext_a_s     = {{(WIDTH+2){a_neg_s}}, iA};
    ext_b_s     = {{(WIDTH+2){b_neg_s}}, iB};
    fast_prod_s = ext_a_s * ext_b_s;
`endif
    case (iControl)
      OPDIV: begin
        if (iB == ZERO) begin
          special_s     = 1'b1;
          special_res_s = ALL_ONES;
        end else if ((iA == MIN_NEG) && (iB == ALL_ONES)) begin
          special_s     = 1'b1;
          special_res_s = iA;
        end else begin
          special_s     = 1'b0;
        end
      end
      OPDIVU: begin
        if (iB == ZERO) begin
          special_s     = 1'b1;
          special_res_s = ALL_ONES;
        end else begin
          special_s     = 1'b0;
        end
      end
      OPREM: begin
        if (iB == ZERO) begin
          special_s     = 1'b1;
          special_res_s = iA;
        end else if ((iA == MIN_NEG) && (iB == ALL_ONES)) begin
          special_s     = 1'b1;
          special_res_s = ZERO;
        end else begin
          special_s     = 1'b0;
        end
      end
      OPREMU: begin
        if (iB == ZERO) begin
          special_s     = 1'b1;
          special_res_s = iA;
        end else begin
          special_s     = 1'b0;
        end
      end
      OPMUL: begin
`ifdef MULDIV_FAST_MUL_EN
        special_s     = 1'b1;
        special_res_s = fast_prod_s[WIDTH-1:0];
`else
        special_s     = 1'b0;
`endif
      end
      OPMULH, OPMULHSU, OPMULHU: begin
`ifdef MULDIV_FAST_MUL_EN
        special_s     = 1'b1;
        special_res_s = fast_prod_s[2*WIDTH-1:WIDTH];
`else
        special_s     = 1'b0;
`endif
      end
      default: begin
        // Unsupported code: zero, same as the ALU default.
        special_s     = 1'b1;
        special_res_s = ZERO;
      end
    endcase
  end

  // Sign fix-up and field selection of the iterated result.
  always_comb begin
    prod_s = res_neg_q ? (~core_acc_s + (2*WIDTH)'(1)) : core_acc_s;
    quo_s  = res_neg_q ? (~core_acc_s[WIDTH-1:0] + WIDTH'(1))
                       : core_acc_s[WIDTH-1:0];
    rem_s  = res_neg_q ? (~core_acc_s[2*WIDTH-1:WIDTH] + WIDTH'(1))
                       : core_acc_s[2*WIDTH-1:WIDTH];
    case (op_q)
      OPMUL:                     fixed_s = prod_s[WIDTH-1:0];
      OPMULH, OPMULHSU, OPMULHU: fixed_s = prod_s[2*WIDTH-1:WIDTH];
      OPDIV, OPDIVU:             fixed_s = quo_s;
      OPREM, OPREMU:             fixed_s = rem_s;
      default:                   fixed_s = ZERO;
    endcase
  end

  // Control FSM next state. oDone is raised on the edge that leaves DONE, so
  // the pulse cycle is spent in IDLE with busy still set; acceptance requires
  // busy clear, which keeps iStart ignored during that cycle.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    op_d        = op_q;
    res_neg_d   = res_neg_q;
    special_d   = special_q;
    spec_res_d  = spec_res_q;
    core_load_s = 1'b0;
    core_step_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (iStart && !busy_q) begin
          busy_d     = 1'b1;
          op_d       = iControl;
          res_neg_d  = res_neg_s;
          special_d  = special_s;
          spec_res_d = special_res_s;
          if (special_s) begin
            state_d = DONE;
            count_d = CW'(0);
          end else begin
            state_d     = RUN;
            count_d     = CW'(WIDTH);
            core_load_s = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      RUN: begin
        core_step_s = 1'b1;
        count_d     = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        done_d   = 1'b1;
        result_d = special_q ? spec_res_q : fixed_s;
        state_d  = IDLE;
        count_d  = CW'(0);
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        count_d = CW'(0);
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= IDLE;
      count_q    <= CW'(0);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= ZERO;
      op_q       <= 5'd0;
      res_neg_q  <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= ZERO;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      op_q       <= op_d;
      res_neg_q  <= res_neg_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
    end
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (iCLK),
    .rst_n    (iRST_n),
    .load     (core_load_s),
    .step     (core_step_s),
    .mode_div (is_div_op(iControl)),
    .op_a     (mag_a_s),
    .op_b     (mag_b_s),
    .acc      (core_acc_s)
  );

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oResult = result_q;

endmodule
